// File: rtl/fp_wb_sched_pkg.sv
// Shared FP definitions for the writeback scheduler: widths, unit indices,
// default unit latencies and the write-port payload type.
package fp_wb_sched_pkg;

    localparam int unsigned FP_REG_WIDTH = 43;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned NUM_UNITS    = 6;

    // Unit indices; lower index wins both at issue and at writeback
    localparam int unsigned U_DIV    = 0;
    localparam int unsigned U_SQRT   = 1;
    localparam int unsigned U_MUL    = 2;
    localparam int unsigned U_ADDSUB = 3;
    localparam int unsigned U_ABS1   = 4;
    localparam int unsigned U_ABS2   = 5;

    // Default issue-to-result latencies
    localparam int unsigned LAT_ADDSUB_DEF = 7;
    localparam int unsigned LAT_MUL_DEF    = 5;
    localparam int unsigned LAT_DIV_DEF    = 14;
    localparam int unsigned LAT_SQRT_DEF   = 12;
    localparam int unsigned LAT_ABS_DEF    = 0;
    localparam int unsigned RES_DEPTH_DEF  = 16;

    typedef logic [FP_REG_WIDTH-1:0] fp_word_t;
    typedef logic [REG_IDX_W-1:0]    reg_idx_t;

    typedef struct packed {
        logic     en;
        reg_idx_t addr;
        fp_word_t data;
    } wb_port_t;

endpackage

// File: rtl/fp_wb_sched_if.sv
// Issue / result / writeback bundle between the FP issue logic and the
// writeback scheduler.
//   master : drives issue requests, destinations and unit results
//   slave  : returns grants and the two register-file write ports
interface fp_wb_sched_if;
    import fp_wb_sched_pkg::*;

    logic [NUM_UNITS-1:0]                IssueReq;
    logic [NUM_UNITS-1:0][REG_IDX_W-1:0] IssueDest;
    logic [NUM_UNITS-1:0]                IssueGrant;

    fp_word_t AddSubRes;
    fp_word_t MulRes;
    fp_word_t DivRes;
    fp_word_t SqrtRes;
    fp_word_t AbsOpp1Res;
    fp_word_t AbsOpp2Res;

    logic     WbEn0;
    logic     WbEn1;
    reg_idx_t WbAddr0;
    reg_idx_t WbAddr1;
    fp_word_t WbData0;
    fp_word_t WbData1;

    modport master (
        output IssueReq, IssueDest,
        output AddSubRes, MulRes, DivRes, SqrtRes, AbsOpp1Res, AbsOpp2Res,
        input  IssueGrant,
        input  WbEn0, WbEn1, WbAddr0, WbAddr1, WbData0, WbData1
    );

    modport slave (
        input  IssueReq, IssueDest,
        input  AddSubRes, MulRes, DivRes, SqrtRes, AbsOpp1Res, AbsOpp2Res,
        output IssueGrant,
        output WbEn0, WbEn1, WbAddr0, WbAddr1, WbData0, WbData1
    );
endinterface

// File: rtl/fp_tag_delay.sv
// {valid, dest} shift line that tracks an issued op through a unit so its
// tag emerges in the same cycle as the unit's result.
//   clock, nReset : clock, async active-low reset
//   in_valid/dest : tag entering on a granted issue
//   out_valid/dest: tag emerging LEN cycles later (same cycle when LEN = 0)
module fp_tag_delay
    import fp_wb_sched_pkg::*;
#(
    parameter int unsigned LEN = 1
) (
    input  logic     clock,
    input  logic     nReset,
    input  logic     in_valid,
    input  reg_idx_t in_dest,
    output logic     out_valid,
    output reg_idx_t out_dest
);

    if (LEN == 0) begin : g_wire
        // Combinational unit: tag is already aligned with its result
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clock, nReset};
        assign out_valid      = in_valid;
        assign out_dest       = in_dest;
    end else begin : g_line
        logic     valid_q [LEN];
        logic     valid_d [LEN];
        reg_idx_t dest_q  [LEN];
        reg_idx_t dest_d  [LEN];

        // Next stage contents: new tag at stage 0, everything else moves up
        always_comb begin
            valid_d[0] = in_valid;
            dest_d[0]  = in_dest;
            for (int i = 1; i < LEN; i++) begin
                valid_d[i] = valid_q[i-1];
                dest_d[i]  = dest_q[i-1];
            end
        end

        always_ff @(posedge clock or negedge nReset) begin
            if (!nReset) begin
                for (int i = 0; i < LEN; i++) begin
                    valid_q[i] <= 1'b0;
                    dest_q[i]  <= '0;
                end
            end else begin
                valid_q <= valid_d;
                dest_q  <= dest_d;
            end
        end

        assign out_valid = valid_q[LEN-1];
        assign out_dest  = dest_q[LEN-1];
    end

endmodule

// File: rtl/fp_wb_sched.sv
// FP writeback scheduler: books register-file write slots at issue time so
// at most two results write back per cycle, then steers emerging results
// onto two registered write ports.
//   clock, nReset : clock, async active-low reset
//   bus (slave)   : IssueReq/IssueDest in, IssueGrant out (combinational),
//                   unit results in, WbEn/WbAddr/WbData x2 out (registered)
module fp_wb_sched
    import fp_wb_sched_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = LAT_ADDSUB_DEF,
    parameter int unsigned LAT_MUL    = LAT_MUL_DEF,
    parameter int unsigned LAT_DIV    = LAT_DIV_DEF,
    parameter int unsigned LAT_SQRT   = LAT_SQRT_DEF,
    parameter int unsigned LAT_ABS    = LAT_ABS_DEF,
    parameter int unsigned RES_DEPTH  = RES_DEPTH_DEF
) (
    input  logic clock,
    input  logic nReset,
    fp_wb_sched_if.slave bus
);

    localparam int unsigned LAT [NUM_UNITS] =
        '{LAT_DIV, LAT_SQRT, LAT_MUL, LAT_ADDSUB, LAT_ABS, LAT_ABS};

    // res_q[i] = writebacks already booked for i+1 cycles from now
    logic [1:0] res_q [RES_DEPTH];
    logic [1:0] res_d [RES_DEPTH];
    logic [1:0] cnt   [RES_DEPTH];

    logic [NUM_UNITS-1:0] grant_c;
    logic [NUM_UNITS-1:0] emerge_valid;
    reg_idx_t             emerge_dest [NUM_UNITS];
    fp_word_t             unit_res    [NUM_UNITS];

    wb_port_t wb0_q, wb0_d;
    wb_port_t wb1_q, wb1_d;

    assign unit_res[U_DIV]    = bus.DivRes;
    assign unit_res[U_SQRT]   = bus.SqrtRes;
    assign unit_res[U_MUL]    = bus.MulRes;
    assign unit_res[U_ADDSUB] = bus.AddSubRes;
    assign unit_res[U_ABS1]   = bus.AbsOpp1Res;
    assign unit_res[U_ABS2]   = bus.AbsOpp2Res;

    // Priority grant against the booking table, then age the table by one
    // cycle; a unit with latency L writes back L+1 cycles after issue.
    always_comb begin
        grant_c = '0;
        for (int k = 0; k < RES_DEPTH; k++) begin
            cnt[k] = res_q[k];
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (nReset && bus.IssueReq[u] && (cnt[LAT[u]] < 2'd2)) begin
                grant_c[u]   = 1'b1;
                cnt[LAT[u]]  = cnt[LAT[u]] + 2'd1;
            end
        end
        for (int k = 0; k < RES_DEPTH - 1; k++) begin
            res_d[k] = cnt[k+1];
        end
        res_d[RES_DEPTH-1] = '0;
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        fp_tag_delay #(
            .LEN (LAT[u])
        ) u_tag_delay (
            .clock     (clock),
            .nReset    (nReset),
            .in_valid  (grant_c[u]),
            .in_dest   (bus.IssueDest[u]),
            .out_valid (emerge_valid[u]),
            .out_dest  (emerge_dest[u])
        );
    end

    // Emerging results fill port 0 then port 1 in unit priority order;
    // address/data hold while a port is idle.
    always_comb begin
        wb0_d    = wb0_q;
        wb1_d    = wb1_q;
        wb0_d.en = 1'b0;
        wb1_d.en = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (emerge_valid[u]) begin
                if (!wb0_d.en) begin
                    wb0_d = '{en: 1'b1, addr: emerge_dest[u], data: unit_res[u]};
                end else if (!wb1_d.en) begin
                    wb1_d = '{en: 1'b1, addr: emerge_dest[u], data: unit_res[u]};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < RES_DEPTH; k++) begin
                res_q[k] <= '0;
            end
            wb0_q <= '0;
            wb1_q <= '0;
        end else begin
            res_q <= res_d;
            wb0_q <= wb0_d;
            wb1_q <= wb1_d;
        end
    end

    assign bus.IssueGrant = grant_c;
    assign bus.WbEn0      = wb0_q.en;
    assign bus.WbAddr0    = wb0_q.addr;
    assign bus.WbData0    = wb0_q.data;
    assign bus.WbEn1      = wb1_q.en;
    assign bus.WbAddr1    = wb1_q.addr;
    assign bus.WbData1    = wb1_q.data;

endmodule

// File: tb/tb_fp_wb_sched.sv
// Self-checking bench for fp_wb_sched: directed scenarios followed by a long
// random issue stream, all compared against a model that books writebacks
// by absolute cycle number.
module tb_fp_wb_sched;
    import fp_wb_sched_pkg::*;

    logic clock = 1'b0;
    logic nReset;

    fp_wb_sched_if bus ();

    fp_wb_sched dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Unit latencies in priority order DIV, SQRT, MUL, ADDSUB, ABS1, ABS2
    int unsigned lat [NUM_UNITS] = '{14, 12, 5, 7, 0, 0};

    typedef struct {
        int          unit;
        logic [4:0]  dest;
        longint      emerge;
    } pend_t;

    pend_t   pend [$];
    int      booked [longint];
    longint  cyc;

    logic [FP_REG_WIDTH-1:0]     rdata [NUM_UNITS];
    logic [NUM_UNITS-1:0][4:0]   dst;
    logic [NUM_UNITS-1:0]        last_grant;

    logic                    exp_en0, exp_en1;
    logic [4:0]              exp_a0, exp_a1;
    logic [FP_REG_WIDTH-1:0] exp_d0, exp_d1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int slot_count(input longint w);
        return booked.exists(w) ? booked[w] : 0;
    endfunction

    function automatic void rand_res();
        for (int u = 0; u < NUM_UNITS; u++) begin
            rdata[u] = FP_REG_WIDTH'({$urandom, $urandom});
        end
    endfunction

    function automatic void model_clear();
        pend.delete();
        booked.delete();
        exp_en0 = 1'b0; exp_en1 = 1'b0;
        exp_a0  = '0;   exp_a1  = '0;
        exp_d0  = '0;   exp_d1  = '0;
    endfunction

    task automatic drive_res();
        bus.DivRes     = rdata[0];
        bus.SqrtRes    = rdata[1];
        bus.MulRes     = rdata[2];
        bus.AddSubRes  = rdata[3];
        bus.AbsOpp1Res = rdata[4];
        bus.AbsOpp2Res = rdata[5];
    endtask

    task automatic check_outputs();
        chk("wb_en0",   64'(bus.WbEn0),   64'(exp_en0));
        chk("wb_addr0", 64'(bus.WbAddr0), 64'(exp_a0));
        chk("wb_data0", 64'(bus.WbData0), 64'(exp_d0));
        chk("wb_en1",   64'(bus.WbEn1),   64'(exp_en1));
        chk("wb_addr1", 64'(bus.WbAddr1), 64'(exp_a1));
        chk("wb_data1", 64'(bus.WbData1), 64'(exp_d1));
    endtask

    // One clock cycle; entered and left at 1 time unit after a rising edge
    task automatic cycle(input logic [NUM_UNITS-1:0] req);
        logic [NUM_UNITS-1:0] mg;
        int nw;
        pend_t p;
        check_outputs();
        bus.IssueReq  = req;
        bus.IssueDest = dst;
        drive_res();
        #1;
        mg = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            longint w;
            w = cyc + longint'(lat[u]) + 1;
            if (req[u] && slot_count(w) < 2) begin
                mg[u]     = 1'b1;
                booked[w] = slot_count(w) + 1;
                p.unit    = u;
                p.dest    = dst[u];
                p.emerge  = cyc + longint'(lat[u]);
                pend.push_back(p);
            end
        end
        last_grant = bus.IssueGrant;
        chk("grant", 64'(last_grant), 64'(mg));
        // Results on the bus this cycle are written on the next cycle
        exp_en0 = 1'b0;
        exp_en1 = 1'b0;
        nw = 0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].unit == u && pend[i].emerge == cyc) begin
                    if (nw == 0) begin
                        exp_en0 = 1'b1; exp_a0 = pend[i].dest; exp_d0 = rdata[u];
                    end else if (nw == 1) begin
                        exp_en1 = 1'b1; exp_a1 = pend[i].dest; exp_d1 = rdata[u];
                    end
                    nw++;
                end
            end
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].emerge == cyc) pend.delete(i);
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0);
    endtask

    // One-cycle reset with every request raised
    task automatic do_reset();
        nReset       = 1'b0;
        bus.IssueReq = '1;
        #1;
        model_clear();
        chk("rst_grant", 64'(bus.IssueGrant), 64'(0));
        check_outputs();
        @(posedge clock);
        #1;
        chk("rst_hold_grant", 64'(bus.IssueGrant), 64'(0));
        check_outputs();
        nReset       = 1'b1;
        bus.IssueReq = '0;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_UNITS-1:0] req;
        nReset        = 1'b0;
        bus.IssueReq  = '0;
        bus.IssueDest = '0;
        dst           = '0;
        for (int u = 0; u < NUM_UNITS; u++) rdata[u] = '0;
        drive_res();
        cyc = 0;
        model_clear();
        @(posedge clock);
        #1;
        do_reset();

        // Single MUL to r3, result presented 5 cycles after issue
        dst[2] = 5'd3;
        cycle(6'b000100);
        chk("mul_grant", 64'(last_grant), 64'(6'b000100));
        idle(4);
        rdata[2] = 43'h12345678;
        cycle('0);
        chk("mul_wb_en0",   64'(bus.WbEn0),   64'(1));
        chk("mul_wb_addr0", 64'(bus.WbAddr0), 64'(3));
        chk("mul_wb_data0", 64'(bus.WbData0), 64'(43'h12345678));
        chk("mul_wb_en1",   64'(bus.WbEn1),   64'(0));
        idle(3);

        // DIV, SQRT and ADDSUB all targeting the same writeback cycle
        idle(20);
        dst = {5'd5, 5'd4, 5'd12, 5'd11, 5'd10, 5'd9};
        rand_res();
        cycle(6'b000001);
        chk("col_div_grant", 64'(last_grant), 64'(6'b000001));
        idle(1);
        cycle(6'b000010);
        chk("col_sqrt_grant", 64'(last_grant), 64'(6'b000010));
        idle(4);
        cycle(6'b001000);
        chk("col_addsub_grant", 64'(last_grant), 64'(6'b000000));
        idle(16);

        // All six at once; ABS pair writes next cycle with the same dest
        idle(20);
        dst = {5'd9, 5'd9, 5'd4, 5'd2, 5'd1, 5'd6};
        rand_res();
        cycle(6'b111111);
        chk("all_grant", 64'(last_grant), 64'(6'b111111));
        chk("abs_wb_en0",   64'(bus.WbEn0),   64'(1));
        chk("abs_wb_addr0", 64'(bus.WbAddr0), 64'(9));
        chk("abs_wb_data0", 64'(bus.WbData0), 64'(rdata[4]));
        chk("abs_wb_en1",   64'(bus.WbEn1),   64'(1));
        chk("abs_wb_addr1", 64'(bus.WbAddr1), 64'(9));
        chk("abs_wb_data1", 64'(bus.WbData1), 64'(rdata[5]));
        idle(20);

        // ADDSUB + MUL fill the next-cycle slot, ABS pair is refused
        dst = {5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd16};
        cycle(6'b001000);
        idle(1);
        cycle(6'b000100);
        idle(4);
        cycle(6'b110000);
        chk("full_abs_grant", 64'(last_grant), 64'(6'b000000));
        idle(20);

        // MUL alone leaves one free entry: ABS1 wins it, ABS2 refused
        cycle(6'b000100);
        idle(4);
        cycle(6'b110000);
        chk("half_abs_grant", 64'(last_grant), 64'(6'b010000));
        idle(20);

        // Reset while a DIV is in flight: its writeback must never appear
        dst = '0;
        dst[0] = 5'd7;
        cycle(6'b000001);
        chk("rst_div_grant", 64'(last_grant), 64'(6'b000001));
        idle(4);
        do_reset();
        for (int i = 0; i < RES_DEPTH_DEF; i++) begin
            chk("res_clear", 64'(dut.res_q[i]), 64'(0));
        end
        for (int i = 0; i < 16; i++) begin
            cycle('0);
            chk("rst_no_wb0", 64'(bus.WbEn0), 64'(0));
            chk("rst_no_wb1", 64'(bus.WbEn1), 64'(0));
        end

        // Random issue stream with varying request density
        for (int i = 0; i < 10000; i++) begin
            rand_res();
            for (int u = 0; u < NUM_UNITS; u++) dst[u] = 5'($urandom);
            if ((i % 1000) < 500) req = 6'($urandom);
            else                  req = 6'($urandom) & 6'($urandom);
            if (i == 5000) do_reset();
            cycle(req);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
